// File: rtl/timer_event_ctrl.sv
// Turns counter match/ovf levels into sticky flags, saturating overrun counts, a registered irq and a one-shot enable gate.
// Flags 1 cycle, irq 2 cycles after an event edge; en_out is combinational; no backpressure. Capture register: TIMER_CAPTURE_EN.
module timer_event_ctrl #(
  parameter int BIN   = 32,
  parameter int OVR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_in,
  input  logic             oneshot,
  input  logic [BIN-1:0]   cnt_value,
  input  logic             match,
  input  logic             ovf,
  input  logic [1:0]       irq_mask,
  input  logic             clr_match,
  input  logic             clr_ovf,
  output logic             en_out,
  output logic             match_flag,
  output logic             ovf_flag,
  output logic [OVR_W-1:0] match_ovr,
  output logic [OVR_W-1:0] ovf_ovr,
  output logic             irq,
  output logic [BIN-1:0]   cap_value,
  output logic             cap_valid
);

  localparam logic [OVR_W-1:0] OVR_MAX = '1;
  localparam logic [OVR_W-1:0] OVR_ONE = {{(OVR_W-1){1'b0}}, 1'b1};

  logic             match_prev_q, ovf_prev_q;
  logic             match_flag_q, match_flag_d;
  logic             ovf_flag_q, ovf_flag_d;
  logic [OVR_W-1:0] match_ovr_q, match_ovr_d;
  logic [OVR_W-1:0] ovf_ovr_q, ovf_ovr_d;
  logic             irq_q, irq_d;
  logic             match_evt, ovf_evt;

  assign match_evt = match & ~match_prev_q;
  assign ovf_evt   = ovf & ~ovf_prev_q;

  // A new event in the same cycle as its clear re-sets the flag but is not an overrun.
  always_comb begin
    match_flag_d = match_flag_q;
    if (match_evt)      match_flag_d = 1'b1;
    else if (clr_match) match_flag_d = 1'b0;

    ovf_flag_d = ovf_flag_q;
    if (ovf_evt)      ovf_flag_d = 1'b1;
    else if (clr_ovf) ovf_flag_d = 1'b0;

    match_ovr_d = match_ovr_q;
    if (clr_match)
      match_ovr_d = '0;
    else if (match_evt && match_flag_q && (match_ovr_q != OVR_MAX))
      match_ovr_d = match_ovr_q + OVR_ONE;

    ovf_ovr_d = ovf_ovr_q;
    if (clr_ovf)
      ovf_ovr_d = '0;
    else if (ovf_evt && ovf_flag_q && (ovf_ovr_q != OVR_MAX))
      ovf_ovr_d = ovf_ovr_q + OVR_ONE;

    irq_d = (match_flag_q & irq_mask[0]) | (ovf_flag_q & irq_mask[1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      match_prev_q <= 1'b0;
      ovf_prev_q   <= 1'b0;
      match_flag_q <= 1'b0;
      ovf_flag_q   <= 1'b0;
      match_ovr_q  <= '0;
      ovf_ovr_q    <= '0;
      irq_q        <= 1'b0;
    end else begin
      match_prev_q <= match;
      ovf_prev_q   <= ovf;
      match_flag_q <= match_flag_d;
      ovf_flag_q   <= ovf_flag_d;
      match_ovr_q  <= match_ovr_d;
      ovf_ovr_q    <= ovf_ovr_d;
      irq_q        <= irq_d;
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic [BIN-1:0] cap_value_q;
  logic           cap_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_value_q <= '0;
      cap_valid_q <= 1'b0;
    end else if (match_evt) begin
      cap_value_q <= cnt_value;
      cap_valid_q <= 1'b1;
    end else if (clr_match) begin
      cap_valid_q <= 1'b0;
    end
  end

  assign cap_value = cap_value_q;
  assign cap_valid = cap_valid_q;
`else
  logic unused_cnt_value;
  assign unused_cnt_value = ^cnt_value;
  assign cap_value = '0;
  assign cap_valid = 1'b0;
`endif

  // One-shot gate acts on the registered flag, so the stop lands the cycle after the match edge.
  assign en_out     = enable_in & ~(oneshot & match_flag_q);
  assign match_flag = match_flag_q;
  assign ovf_flag   = ovf_flag_q;
  assign match_ovr  = match_ovr_q;
  assign ovf_ovr    = ovf_ovr_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_timer_event_ctrl.sv
// Directed literal checks plus randomized traffic compared every cycle against an event-counting model.
module tb_timer_event_ctrl;
  localparam int BIN   = 32;
  localparam int OVR_W = 4;
  localparam int OVR_SAT = (1 << OVR_W) - 1;

  logic             clk = 1'b0;
  logic             reset, enable_in, oneshot, match, ovf, clr_match, clr_ovf;
  logic [BIN-1:0]   cnt_value;
  logic [1:0]       irq_mask;
  logic             en_out, match_flag, ovf_flag, irq, cap_valid;
  logic [OVR_W-1:0] match_ovr, ovf_ovr;
  logic [BIN-1:0]   cap_value;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  timer_event_ctrl #(.BIN(BIN), .OVR_W(OVR_W)) dut (
    .clk(clk), .reset(reset), .enable_in(enable_in), .oneshot(oneshot),
    .cnt_value(cnt_value), .match(match), .ovf(ovf), .irq_mask(irq_mask),
    .clr_match(clr_match), .clr_ovf(clr_ovf), .en_out(en_out),
    .match_flag(match_flag), .ovf_flag(ovf_flag), .match_ovr(match_ovr),
    .ovf_ovr(ovf_ovr), .irq(irq), .cap_value(cap_value), .cap_valid(cap_valid)
  );

  always #5 clk = ~clk;

  // Model: count events since the last clear; flag = any, overruns = the rest (saturated).
  int          pend_m, pend_o;
  bit          prev_m, prev_o, m_irq, m_cap_valid;
  logic [31:0] m_cap_value;

  always @(posedge clk) begin
    automatic bit evm = match && !prev_m;
    automatic bit evo = ovf && !prev_o;
    if (reset) begin
      pend_m = 0; pend_o = 0; prev_m = 0; prev_o = 0;
      m_irq = 0; m_cap_valid = 0; m_cap_value = 0;
    end else begin
      m_irq = ((pend_m > 0) && irq_mask[0]) || ((pend_o > 0) && irq_mask[1]);
      if (clr_match) begin pend_m = 0; m_cap_valid = 0; end
      if (clr_ovf) pend_o = 0;
      if (evm) begin
        pend_m = pend_m + 1;
        m_cap_valid = 1;
        m_cap_value = cnt_value;
      end
      if (evo) pend_o = pend_o + 1;
      prev_m = match;
      prev_o = ovf;
    end
  end

  function automatic int exp_ovr(input int pend);
    if (pend == 0) return 0;
    return (pend - 1 > OVR_SAT) ? OVR_SAT : pend - 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("en_out", en_out, enable_in & ~(oneshot & (pend_m > 0)));
      chk("match_flag", match_flag, pend_m > 0);
      chk("ovf_flag", ovf_flag, pend_o > 0);
      chk("match_ovr", match_ovr, exp_ovr(pend_m));
      chk("ovf_ovr", ovf_ovr, exp_ovr(pend_o));
      chk("irq", irq, m_irq);
`ifdef TIMER_CAPTURE_EN
      chk("cap_valid", cap_valid, m_cap_valid);
      chk("cap_value", cap_value, m_cap_value);
`else
      chk("cap_valid", cap_valid, 0);
      chk("cap_value", cap_value, 0);
`endif
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1; enable_in = 0; oneshot = 0; match = 0; ovf = 0;
    clr_match = 0; clr_ovf = 0; irq_mask = 2'b00; cnt_value = '0;
    tick(2);
    chk_en = 1;
    reset = 0;
    tick();
    chk("rst_match_flag", match_flag, 0);
    chk("rst_irq", irq, 0);
    chk("rst_en_out", en_out, 0);

    // Single match, held 3 cycles
    irq_mask = 2'b01; cnt_value = 25; match = 1;
    tick();
    chk("single_flag", match_flag, 1);
    chk("single_irq_early", irq, 0);
    tick();
    chk("single_irq", irq, 1);
    chk("single_ovr", match_ovr, 0);
    tick();
    match = 0; cnt_value = 99;
`ifdef TIMER_CAPTURE_EN
    chk("single_cap_value", cap_value, 25);
    chk("single_cap_valid", cap_valid, 1);
`else
    chk("single_cap_value", cap_value, 0);
    chk("single_cap_valid", cap_valid, 0);
`endif
    clr_match = 1; tick(); clr_match = 0;
    chk("single_clr_flag", match_flag, 0);
    tick();

    // Overrun saturation
    for (int i = 0; i < 20; i++) begin
      match = 1; tick(); match = 0; tick();
    end
    chk("sat_flag", match_flag, 1);
    chk("sat_ovr", match_ovr, 15);
    clr_match = 1; tick(); clr_match = 0;
    chk("sat_clr_flag", match_flag, 0);
    chk("sat_clr_ovr", match_ovr, 0);
    tick();
    chk("sat_clr_irq", irq, 0);

    // Simultaneous set and clear on ovf
    for (int i = 0; i < 4; i++) begin
      ovf = 1; tick(); ovf = 0; tick();
    end
    chk("sc_ovr_pre", ovf_ovr, 3);
    ovf = 1; clr_ovf = 1; tick(); ovf = 0; clr_ovf = 0;
    chk("sc_flag", ovf_flag, 1);
    chk("sc_ovr", ovf_ovr, 0);
    clr_ovf = 1; tick(); clr_ovf = 0;

    // One-shot
    enable_in = 1; oneshot = 1; tick();
    chk("os_armed", en_out, 1);
    match = 1; tick();
    chk("os_stop", en_out, 0);
    match = 0; tick(3);
    chk("os_hold", en_out, 0);
    clr_match = 1; tick(); clr_match = 0;
    chk("os_rearm", en_out, 1);

    // Mask
    irq_mask = 2'b00; match = 1; ovf = 1; tick(); match = 0; ovf = 0; tick(2);
    chk("mask_mflag", match_flag, 1);
    chk("mask_oflag", ovf_flag, 1);
    chk("mask_irq0", irq, 0);
    irq_mask = 2'b10; tick();
    chk("mask_irq1", irq, 1);

    // Reset mid-operation with match held high through it
    for (int i = 0; i < 5; i++) begin
      match = 1; tick(); match = 0; tick();
    end
    irq_mask = 2'b11; tick(2);
    chk("mid_ovr", match_ovr, 5);
    chk("mid_irq", irq, 1);
    match = 1; reset = 1; tick(); reset = 0;
    chk("mid_rst_mflag", match_flag, 0);
    chk("mid_rst_oflag", ovf_flag, 0);
    chk("mid_rst_ovr", match_ovr, 0);
    chk("mid_rst_irq", irq, 0);
    chk("mid_rst_cap", cap_valid, 0);
    chk("mid_rst_en", en_out, 1);
    tick();
    chk("mid_post_flag", match_flag, 1);
    match = 0; tick();

    // Randomized traffic with varying clear density
    for (int blk = 0; blk < 6; blk++) begin
      automatic int clr_div = (blk % 3 == 0) ? 2 : ((blk % 3 == 1) ? 8 : 64);
      for (int i = 0; i < 500; i++) begin
        reset     = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 2) == 0) match = ~match;
        if ($urandom_range(0, 2) == 0) ovf = ~ovf;
        clr_match = ($urandom_range(0, clr_div - 1) == 0);
        clr_ovf   = ($urandom_range(0, clr_div - 1) == 0);
        if ($urandom_range(0, 15) == 0) irq_mask = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) enable_in = ~enable_in;
        if ($urandom_range(0, 31) == 0) oneshot = ~oneshot;
        cnt_value = $urandom;
        tick();
      end
    end

    reset = 0; clr_match = 0; clr_ovf = 0;
    tick(2);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
